// File: rtl/count_tick_gen.sv
// Advance-enable source for the display counter: rate divider or debounced step button.
// Build option: define STEP_AUTOREPEAT_EN to auto-repeat ticks while the step button is held.
module count_tick_gen #(
    parameter int CLK_HZ            = 50000000,
    parameter int DEBOUNCE_CYCLES   = 1000000,
    parameter int AUTOREPEAT_CYCLES = 25000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable_in,
    input  logic       mode,
    input  logic [1:0] rate_sel,
    input  logic       step_btn_n,
    output logic       tick,
    output logic       heartbeat
);

    localparam int DW = $clog2(4 * CLK_HZ);
    localparam int BW = $clog2(DEBOUNCE_CYCLES + 2);

    typedef enum logic [1:0] {
        S_HOLD,
        S_RUN,
        S_ARMED,
        S_RELEASE
    } state_e;

    state_e state_q, state_d;

    logic          sync1_q, sync2_q;
    logic          db_state_q, db_state_d;
    logic          db_prev_q;
    logic [BW-1:0] db_cnt_q, db_cnt_d;
    logic          db_diff, db_accept;
    logic          need_rel_q, need_rel_d;
    logic [BW-1:0] rel_cnt_q, rel_cnt_d;
    logic          rel_done;
    logic          press_evt;

    logic [1:0]    rate_q;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [DW-1:0] div_max;
    logic          tick_run;

    logic          rep_fire;
    logic          tick_q, tick_d;
    logic          hb_q, hb_d;

    // Debouncer: only the second synchroniser flop is ever looked at
    always_comb begin
        db_diff    = (sync2_q != db_state_q);
        db_accept  = db_diff && (db_cnt_q == BW'(DEBOUNCE_CYCLES - 1));
        db_cnt_d   = (!db_diff || db_accept) ? '0 : db_cnt_q + 1'b1;
        db_state_d = db_accept ? sync2_q : db_state_q;
    end

    // After reset a held button must be seen released (past the sync flush) before it can step
    always_comb begin
        rel_done   = (rel_cnt_q == BW'(DEBOUNCE_CYCLES + 1));
        rel_cnt_d  = (need_rel_q && sync2_q && !rel_done) ? rel_cnt_q + 1'b1 : '0;
        need_rel_d = need_rel_q && !rel_done;
        press_evt  = db_prev_q && !db_state_q && !need_rel_q;
    end

    always_comb begin
        div_max = '0;
        case (rate_sel)
            2'b00:   div_max = '0;
            2'b01:   div_max = DW'(CLK_HZ - 1);
            2'b10:   div_max = DW'(2 * CLK_HZ - 1);
            default: div_max = DW'(4 * CLK_HZ - 1);
        endcase
    end

    always_comb begin
        div_cnt_d = '0;
        if (state_q == S_RUN && rate_sel == rate_q && div_cnt_q != div_max)
            div_cnt_d = div_cnt_q + 1'b1;
        tick_run = (state_q == S_RUN) && (div_cnt_q == div_max);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HOLD: begin
                if (enable_in)
                    state_d = mode ? S_ARMED : S_RUN;
            end
            S_RUN: begin
                if (!enable_in)
                    state_d = S_HOLD;
                else if (mode)
                    state_d = S_ARMED;
            end
            S_ARMED: begin
                if (!enable_in)
                    state_d = S_HOLD;
                else if (!mode)
                    state_d = S_RUN;
                else if (press_evt)
                    state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (!enable_in)
                    state_d = S_HOLD;
                else if (!mode)
                    state_d = S_RUN;
                else if (db_state_q)
                    state_d = S_ARMED;
            end
            default: state_d = S_HOLD;
        endcase
    end

`ifdef STEP_AUTOREPEAT_EN
    localparam int HW = $clog2(AUTOREPEAT_CYCLES + 1);

    logic [HW-1:0] hold_cnt_q, hold_cnt_d;

    always_comb begin
        hold_cnt_d = '0;
        rep_fire   = 1'b0;
        if (state_q == S_RELEASE && !db_state_q) begin
            if (hold_cnt_q == HW'(AUTOREPEAT_CYCLES - 1))
                rep_fire = 1'b1;
            else if (state_d == S_RELEASE)
                hold_cnt_d = hold_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            hold_cnt_q <= '0;
        else
            hold_cnt_q <= hold_cnt_d;
    end
`else
    // Without auto-repeat a held button never ticks again
    assign rep_fire = (AUTOREPEAT_CYCLES < 0);
`endif

    always_comb begin
        tick_d = tick_run || (state_q == S_ARMED && press_evt) || rep_fire;
        hb_d   = hb_q ^ tick_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_HOLD;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            db_state_q <= 1'b1;
            db_prev_q  <= 1'b1;
            db_cnt_q   <= '0;
            need_rel_q <= 1'b1;
            rel_cnt_q  <= '0;
            rate_q     <= 2'b00;
            div_cnt_q  <= '0;
            tick_q     <= 1'b0;
            hb_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= step_btn_n;
            sync2_q    <= sync1_q;
            db_state_q <= db_state_d;
            db_prev_q  <= db_state_q;
            db_cnt_q   <= db_cnt_d;
            need_rel_q <= need_rel_d;
            rel_cnt_q  <= rel_cnt_d;
            rate_q     <= rate_sel;
            div_cnt_q  <= div_cnt_d;
            tick_q     <= tick_d;
            hb_q       <= hb_d;
        end
    end

    assign tick      = tick_q;
    assign heartbeat = hb_q;

endmodule

// File: tb/tb_count_tick_gen.sv
// Directed bench for count_tick_gen with CLK_HZ=8, DEBOUNCE_CYCLES=4, AUTOREPEAT_CYCLES=6.
module tb_count_tick_gen;

    localparam int AR = 6;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable_in;
    logic       mode;
    logic [1:0] rate_sel;
    logic       step_btn_n;
    logic       tick;
    logic       heartbeat;

    int passed = 0;
    int total  = 0;
    int tcnt, tfirst, tidx;
    int n;

    count_tick_gen #(
        .CLK_HZ(8),
        .DEBOUNCE_CYCLES(4),
        .AUTOREPEAT_CYCLES(AR)
    ) dut (
        .clock(clock),
        .reset(reset),
        .enable_in(enable_in),
        .mode(mode),
        .rate_sel(rate_sel),
        .step_btn_n(step_btn_n),
        .tick(tick),
        .heartbeat(heartbeat)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic       en;
        logic       md;
        logic [1:0] rs;
        logic       btn;
        logic       xt;
        logic       xh;
    } vec_t;

    vec_t vt[10];

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp)
            passed++;
        else
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic clr();
        tcnt   = 0;
        tfirst = 0;
        tidx   = 0;
    endtask

    task automatic tally(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            cyc();
            tidx++;
            if (tick) begin
                tcnt++;
                if (tfirst == 0)
                    tfirst = tidx;
            end
        end
    endtask

    task automatic press(input int h, input int r);
        clr();
        step_btn_n = 1'b0;
        tally(h);
        step_btn_n = 1'b1;
        tally(r);
    endtask

    task automatic wait_tick(input int lim, output int cnt);
        cnt = -1;
        for (int i = 1; i <= lim; i++) begin
            cyc();
            if (tick) begin
                cnt = i;
                break;
            end
        end
    endtask

    // Ticks from one press held h cycles: first at press+7, repeats every AR while debounced-held
    function automatic int exp_ticks(input int h);
`ifdef STEP_AUTOREPEAT_EN
        return 1 + (h - 1) / AR;
`else
        return (h > 0) ? 1 : 0;
`endif
    endfunction

    initial begin
        vt[0] = '{1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0};
        vt[1] = '{1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0};
        vt[2] = '{1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0};
        vt[3] = '{1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0};
        vt[4] = '{1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1};
        vt[5] = '{1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0};
        vt[6] = '{1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1};
        vt[7] = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0};
        vt[8] = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1};
        vt[9] = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1};

        reset      = 1'b1;
        enable_in  = 1'b0;
        mode       = 1'b0;
        rate_sel   = 2'b00;
        step_btn_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            reset      = vt[i].rst;
            enable_in  = vt[i].en;
            mode       = vt[i].md;
            rate_sel   = vt[i].rs;
            step_btn_n = vt[i].btn;
            cyc();
            chk($sformatf("vec%0d_tick", i), int'(tick), int'(vt[i].xt));
            chk($sformatf("vec%0d_hb", i), int'(heartbeat), int'(vt[i].xh));
        end

        // Rate 01 from HOLD
        enable_in = 1'b1;
        rate_sel  = 2'b01;
        cyc();
        chk("run_entry_tick", int'(tick), 0);
        wait_tick(40, n);
        chk("rate01_first", n, 8);
        wait_tick(40, n);
        chk("rate01_period", n, 8);
        clr();
        tally(3);
        chk("rate01_mid", tcnt, 0);

        // Switch to rate 10 mid-period
        rate_sel = 2'b10;
        cyc();
        chk("rate_change_tick", int'(tick), 0);
        wait_tick(60, n);
        chk("rate10_after_change", n, 16);

        // Pause and resume at rate 10
        enable_in = 1'b0;
        clr();
        tally(5);
        chk("pause10", tcnt, 0);
        enable_in = 1'b1;
        cyc();
        chk("resume10_entry", int'(tick), 0);
        wait_tick(60, n);
        chk("resume10", n, 16);

        // Pause, change to rate 01 while paused, resume
        enable_in = 1'b0;
        rate_sel  = 2'b01;
        clr();
        tally(5);
        chk("pause01", tcnt, 0);
        enable_in = 1'b1;
        cyc();
        wait_tick(40, n);
        chk("resume01", n, 8);

        // Step mode: short bounces do nothing
        mode = 1'b1;
        clr();
        for (int k = 0; k < 3; k++) begin
            step_btn_n = 1'b0;
            tally(3);
            step_btn_n = 1'b1;
            tally(6);
        end
        chk("bounce", tcnt, 0);

        press(20, 12);
        chk("step1_first", tfirst, 7);
        chk("step1_count", tcnt, exp_ticks(20));
        press(20, 12);
        chk("step2_first", tfirst, 7);
        chk("step2_count", tcnt, exp_ticks(20));

        // Reset while the button is held in the release state
        clr();
        step_btn_n = 1'b0;
        tally(10);
        chk("pre_reset_first", tfirst, 7);
        chk("pre_reset_hb", int'(heartbeat), 1);
        reset = 1'b1;
        cyc();
        chk("rst1_tick", int'(tick), 0);
        chk("rst1_hb", int'(heartbeat), 0);
        cyc();
        chk("rst2_tick", int'(tick), 0);
        chk("rst2_hb", int'(heartbeat), 0);
        reset = 1'b0;
        clr();
        tally(20);
        chk("held_after_reset", tcnt, 0);
        step_btn_n = 1'b1;
        tally(15);
        chk("release_after_reset", tcnt, 0);
        press(20, 15);
        chk("repress_first", tfirst, 7);
        chk("repress_count", tcnt, exp_ticks(20));

        // Long hold
        press(40, 20);
        chk("long_hold_first", tfirst, 7);
        chk("long_hold_count", tcnt, exp_ticks(40));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/count_tick_gen.md
Name: count_tick_gen

Overview:
- Upstream stage of the 16-bit display counter. Generates the counter's one-cycle advance enable (`tick`) on the board clock.
- Two sources for `tick`:
  - free-running rate divider, with a selectable rate;
  - debounced single-step push button.
- Replaces feeding the raw KEY into the counter's clock with a clean, single-clock-domain enable.

Parameters:
- CLK_HZ, 50000000, board clock frequency; sets the divider periods.
- DEBOUNCE_CYCLES, 1000000, cycles the synchronised button must stay stable before its state is accepted (20 ms at 50 MHz).
- AUTOREPEAT_CYCLES, 25000000, hold time before auto-repeat starts, and the repeat interval. Used only with the optional feature.

Ports:
- clock  in  1  board clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- enable_in  in  1  master run enable (SW[0]); 0 pauses all tick generation.
- mode  in  1  0 = free-run divider, 1 = single-step from button.
- rate_sel  in  2  divider period P: 00 → 1; 01 → CLK_HZ; 10 → 2*CLK_HZ; 11 → 4*CLK_HZ.
- step_btn_n  in  1  raw push button, active-low (KEY[1]), asynchronous to clock.
- tick  out  1  registered one-cycle advance pulse to the counter.
- heartbeat  out  1  toggles on every tick (LED).

Behaviour:
- Reset (clock edge with reset=1):
  - tick=0, heartbeat=0, div_cnt=0.
  - Synchroniser flops=1, db_state=1 (released), debounce counter=0.
  - FSM enters S_HOLD.
- Button synchroniser: two flops on step_btn_n. All logic uses only the second-flop output.
- Debouncer:
  - Counter clears whenever sync == db_state.
  - While sync != db_state, counter increments.
  - On the cycle the counter equals DEBOUNCE_CYCLES-1 and sync still differs, db_state takes sync and the counter clears.
  - press_evt is a one-cycle pulse on db_state 1→0.
- Divider:
  - div_cnt width is $clog2(4*CLK_HZ).
  - div_cnt counts 0..P-1 and wraps to 0.
  - Counts only in S_RUN.
  - div_cnt clears on entering S_RUN, and on any cycle where rate_sel differs from its registered copy from the previous cycle.
- FSM states and transitions (evaluated each cycle; reset has priority):
  - S_HOLD: enable_in=0. Go to S_RUN if enable_in=1 and mode=0. Go to S_ARMED if enable_in=1 and mode=1.
  - S_RUN: go to S_HOLD if enable_in=0. Go to S_ARMED if mode=1.
  - S_ARMED: go to S_HOLD if enable_in=0. Go to S_RUN if mode=0. On press_evt, go to S_RELEASE.
  - S_RELEASE: go to S_ARMED when db_state=1. Go to S_HOLD if enable_in=0. Go to S_RUN if mode=0.
- tick timing:
  - In S_RUN, tick=1 in the cycle after a cycle with div_cnt==P-1.
  - In S_ARMED, tick=1 in the cycle after press_evt.
  - Exactly one cycle wide in both cases.
  - A scheduled tick still issues if the FSM leaves the state on the same edge. No tick is ever generated in S_HOLD.
- Rate timing:
  - rate_sel=00: tick every cycle, starting from the 2nd cycle in S_RUN.
  - rate 01: first tick P cycles after entering S_RUN, then every P cycles.
- Step timing: raw press to tick = DEBOUNCE_CYCLES+3 cycles. One press gives exactly one tick, however long the button is held.
- heartbeat inverts on every cycle where tick=1.
- Bounce handling: glitches shorter than DEBOUNCE_CYCLES produce no press_evt.
- Reset mid-operation:
  - A pending tick is dropped.
  - A press in progress must be fully released, then pressed again, before any tick.

Optional Feature:
- STEP_AUTOREPEAT_EN defined:
  - In S_RELEASE, a hold counter runs while db_state=0.
  - At AUTOREPEAT_CYCLES, tick pulses once and the counter restarts. The same repeats every AUTOREPEAT_CYCLES until release.
  - The hold counter clears on release, on a state exit, and on reset.
- Undefined: no hold counter is built; S_RELEASE never ticks.

Test Plan:
- CLK_HZ=8, DEBOUNCE_CYCLES=4, AUTOREPEAT_CYCLES=6 throughout.
- Free-run at full speed: reset 2 cycles; then enable_in=1, mode=0, rate_sel=00.
  → tick=0 in the 1st cycle of S_RUN, then 1 every cycle; heartbeat alternates.
- Rate and pause: rate_sel=01.
  → ticks 8 cycles apart.
  - Switch to rate_sel=10 mid-period → next tick 16 cycles after the change.
  - enable_in=0 for 5 cycles → no tick.
  - enable_in=1 → first tick 8 or 16 cycles later, depending on rate_sel.
- Debounce: mode=1, step_btn_n pulsed low for 3 cycles, three times → no tick.
  - Then held low for 20 cycles → exactly one tick, 7 cycles after the falling edge.
  - Release, press again → second tick.
- Reset mid-press: reset asserted while the button is held in S_RELEASE.
  → tick=0, heartbeat=0.
  - After reset clears, the held button gives no tick until released and re-pressed.
- STEP_AUTOREPEAT_EN: hold the button 40 cycles.
  → ticks at press+7, then every 6 cycles while held; none after release.
  - Without the macro → exactly one tick.
